// File: rtl/scroll_scan_controller.sv
// rtl/scroll_scan_controller.sv - 4-digit anode scan with blanking and run/pause/step scroll scheduler (optional SCROLL_BOUNCE_EN)
module scroll_scan_controller #(
  parameter int SCAN_DIV   = 16,
  parameter int BLANK_CYC  = 2,
  parameter int STEP_TICKS = 1670000,
  parameter int TW         = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause_req,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic [3:0] scroll_pos,
  output logic       blank,
  output logic       step_pulse,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10
  } state_t;

  localparam int            SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_LIM = SW'(BLANK_CYC);
  localparam logic [TW-1:0] TERM_CNT  = TW'(STEP_TICKS - 1);

  state_t        r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [SW-1:0] r_slot,  w_slot_next;
  logic [1:0]    r_digit, w_digit_next;
  logic [3:0]    r_an,    w_an_next;
  logic [3:0]    r_pos,   w_pos_next;
  logic          r_blank, w_blank_next;
  logic          r_pulse, w_advance;
`ifdef SCROLL_BOUNCE_EN
  logic          r_dir,   w_dir_next;
`endif

  // Control FSM: request priority stop > pause_req > step > start; timer frozen while paused
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_next = '0;
        if (!stop && start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          w_state_next = S_IDLE;
          w_timer_next = '0;
        end else begin
          // A terminal count still advances even when a pause lands on the same cycle
          if (r_timer == TERM_CNT) begin
            w_advance    = 1'b1;
            w_timer_next = '0;
          end else if (!pause_req) begin
            w_timer_next = r_timer + 1'b1;
          end
          if (pause_req) w_state_next = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (stop) begin
          w_state_next = S_IDLE;
          w_timer_next = '0;
        end else if (pause_req) begin
          w_state_next = S_RUN;
        end else if (step) begin
          w_advance = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  // Scroll position: cleared in IDLE, otherwise moves one place on each advance
  always_comb begin
    w_pos_next = r_pos;
`ifdef SCROLL_BOUNCE_EN
    w_dir_next = r_dir;
    if (r_state == S_IDLE && w_state_next == S_RUN) w_dir_next = dir;
`endif
    if (w_state_next == S_IDLE) begin
      w_pos_next = '0;
    end else if (w_advance) begin
`ifdef SCROLL_BOUNCE_EN
      if (!r_dir && r_pos == 4'd15) begin
        w_pos_next = 4'd14;
        w_dir_next = 1'b1;
      end else if (r_dir && r_pos == 4'd0) begin
        w_pos_next = 4'd1;
        w_dir_next = 1'b0;
      end else begin
        w_pos_next = r_dir ? r_pos - 4'd1 : r_pos + 4'd1;
      end
`else
      w_pos_next = dir ? r_pos - 4'd1 : r_pos + 4'd1;
`endif
    end
  end

  // Anode scan: slot/digit counters run only while staying out of IDLE, so RUN starts at slot 0
  always_comb begin
    w_slot_next  = '0;
    w_digit_next = '0;
    if (r_state != S_IDLE && w_state_next != S_IDLE) begin
      if (r_slot == LAST_SLOT) begin
        w_slot_next  = '0;
        w_digit_next = r_digit + 2'd1;
      end else begin
        w_slot_next  = r_slot + 1'b1;
        w_digit_next = r_digit;
      end
    end
    w_blank_next = (w_state_next == S_IDLE) || (w_slot_next < BLANK_LIM);
    w_an_next    = 4'b1111;
    if (!w_blank_next) w_an_next[w_digit_next] = 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Datapath registers; every output comes straight from one of these
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer <= '0;
      r_slot  <= '0;
      r_digit <= '0;
      r_an    <= 4'b1111;
      r_pos   <= '0;
      r_blank <= 1'b1;
      r_pulse <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
      r_dir   <= 1'b0;
`endif
    end else begin
      r_timer <= w_timer_next;
      r_slot  <= w_slot_next;
      r_digit <= w_digit_next;
      r_an    <= w_an_next;
      r_pos   <= w_pos_next;
      r_blank <= w_blank_next;
      r_pulse <= w_advance;
`ifdef SCROLL_BOUNCE_EN
      r_dir   <= w_dir_next;
`endif
    end
  end

  assign an         = r_an;
  assign digit_idx  = r_digit;
  assign scroll_pos = r_pos;
  assign blank      = r_blank;
  assign step_pulse = r_pulse;
  assign state      = r_state;

endmodule

// File: tb/tb_scroll_scan_controller.sv
// tb/tb_scroll_scan_controller.sv - scoreboard bench for scroll_scan_controller
module tb_scroll_scan_controller;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause_req, step, dir;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic [3:0] scroll_pos;
  logic       blank, step_pulse;
  logic [1:0] state;

  scroll_scan_controller #(
    .SCAN_DIV(8), .BLANK_CYC(2), .STEP_TICKS(20), .TW(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .pause_req(pause_req), .step(step), .dir(dir),
    .an(an), .digit_idx(digit_idx), .scroll_pos(scroll_pos),
    .blank(blank), .step_pulse(step_pulse), .state(state)
  );

  typedef struct packed {
    logic [3:0] pos;
    logic [1:0] st;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   scan_t0 = 0;
  bit   scan_chk = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] pos, input logic [1:0] st, input int c);
    exp_t e;
    e.pos = pos;
    e.st  = st;
    e.cyc = c;
    q.push_back(e);
  endtask

  // Scan reference: k cycles after entering RUN, slot = k%8, digit = (k/8)%4, first 2 slots blank
  task automatic check_scan();
    int         k, slot, dg;
    logic [3:0] one, ea;
    one  = 4'b0001;
    k    = cyc - scan_t0;
    slot = k % 8;
    dg   = (k / 8) % 4;
    ea   = (slot < 2) ? 4'b1111 : ~(one << dg);
    check("scan_an", an, ea);
    check("scan_digit", digit_idx, dg);
    check("scan_blank", blank, (slot < 2) ? 1 : 0);
  endtask

  task automatic step_cyc();
    @(negedge clk);
    if (scan_chk) check_scan();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step_cyc();
  endtask

  // Monitor: every step_pulse must match the oldest expected advance
  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse @cyc %0d: got pos %0d, expected no pulse", cyc, scroll_pos);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_pos", scroll_pos, e.pos);
        check("pulse_state", state, e.st);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: cyc %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, s, b;
    logic [3:0] ep;
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    pause_req = 1'b0; step = 1'b0; dir = 1'b0;

    wait_until(3);
    reset = 1'b1;
    check("rst_state", state, 2'b00);
    check("rst_an", an, 4'b1111);
    check("rst_pos", scroll_pos, 4'd0);
    check("rst_blank", blank, 1'b1);
    check("rst_pulse", step_pulse, 1'b0);
    check("rst_digit", digit_idx, 2'd0);
    wait_until(5);
    check("idle_an", an, 4'b1111);
    check("idle_state", state, 2'b00);

    // Free run: advances every 20 cycles
    start = 1'b1; dir = 1'b0;
    t0 = cyc + 1;
    for (int i = 1; i <= 5; i++) push(4'(i), 2'b01, t0 + 20 * i);
    step_cyc();
    start = 1'b0;
    check("run_state", state, 2'b01);
    scan_t0 = t0; scan_chk = 1'b1;

    // Pause at timer 7, resume 50 cycles later, next advance 13 cycles after resume
    wait_until(t0 + 107);
    pause_req = 1'b1;
    step_cyc();
    pause_req = 1'b0;
    check("pause_state", state, 2'b10);
    wait_until(t0 + 158);
    pause_req = 1'b1;
    push(4'd6, 2'b01, t0 + 172);
    step_cyc();
    pause_req = 1'b0;
    check("resume_state", state, 2'b01);

    // Stop coincident with the terminal count
    wait_until(t0 + 191);
    stop = 1'b1; scan_chk = 1'b0;
    step_cyc();
    stop = 1'b0;
    check("stop_state", state, 2'b00);
    check("stop_pos", scroll_pos, 4'd0);
    check("stop_an", an, 4'b1111);
    check("stop_blank", blank, 1'b1);
    check("stop_pulse", step_pulse, 1'b0);

    // Step while IDLE is ignored
    step = 1'b1;
    step_cyc();
    step = 1'b0;
    check("idle_step_state", state, 2'b00);
    check("idle_step_pos", scroll_pos, 4'd0);

    // Single-step while PAUSED, descending across 0
    start = 1'b1; s = cyc;
    step_cyc();
    start = 1'b0; pause_req = 1'b1;
    scan_t0 = s + 1; scan_chk = 1'b1;
    step_cyc();
    pause_req = 1'b0; dir = 1'b1; step = 1'b1;
    push(4'd15, 2'b10, s + 3);
    check("step_pause_state", state, 2'b10);
    step_cyc();
    step = 1'b0;
    step_cyc();
    step = 1'b1;
    push(4'd14, 2'b10, s + 5);
    step_cyc();
    step = 1'b0;
    check("step2_state", state, 2'b10);
    check("step2_pos", scroll_pos, 4'd14);
    repeat (3) step_cyc();
    check("paused_hold_pos", scroll_pos, 4'd14);
    stop = 1'b1; scan_chk = 1'b0;
    step_cyc();
    stop = 1'b0; dir = 1'b0;
    check("stop2_state", state, 2'b00);
    check("stop2_pos", scroll_pos, 4'd0);

    // 17 ascending advances: wrap (default) or bounce (SCROLL_BOUNCE_EN)
    start = 1'b1; b = cyc;
    for (int i = 1; i <= 17; i++) begin
`ifdef SCROLL_BOUNCE_EN
      ep = (i <= 15) ? 4'(i) : 4'(30 - i);
`else
      ep = 4'(i % 16);
`endif
      push(ep, 2'b01, b + 1 + 20 * i);
    end
    step_cyc();
    start = 1'b0;
    scan_t0 = b + 1; scan_chk = 1'b1;
    wait_until(b + 1 + 340 + 3);
    scan_chk = 1'b0;
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
